// File: rtl/modiff_pkg.sv
// Shared types and default constants for the modiff pitch pipeline.
// Latency: none, declarations only.
// Backpressure: not applicable.
package modiff_pkg;

   localparam int MODIFF_MAX_TAU    = 40;
   localparam int MODIFF_MIN_TAU    = 2;
   localparam int MODIFF_DIFF_WIDTH = 24;
   localparam int MODIFF_TAU_WIDTH  = 6;

   typedef logic [MODIFF_TAU_WIDTH-1:0] tau_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      EVAL,
      REPORT
   } state_t;

endpackage

// File: rtl/modiff_min_tracker.sv
// Best-lag tracker: keeps the smallest difference seen in a sweep and its lag.
// Latency: one cycle from update to best_tau/best_diff.
// Backpressure: none; clear wins over update, ties keep the earlier (smaller) lag.
module modiff_min_tracker
   import modiff_pkg::*;
#(
   parameter int DIFF_WIDTH = MODIFF_DIFF_WIDTH,
   parameter int TAU_WIDTH  = MODIFF_TAU_WIDTH,
   parameter int MIN_TAU    = MODIFF_MIN_TAU
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  update,
   input  logic [TAU_WIDTH-1:0]  cand_tau,
   input  logic [DIFF_WIDTH-1:0] cand_diff,
   output logic [TAU_WIDTH-1:0]  best_tau,
   output logic [DIFF_WIDTH-1:0] best_diff
);

   // Clear to "worse than anything" so the first lag always wins; strict compare keeps ties on the smaller lag.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         best_diff <= '1;
         best_tau  <= TAU_WIDTH'(MIN_TAU);
      end else if (update && (cand_diff < best_diff)) begin
         best_diff <= cand_diff;
         best_tau  <= cand_tau;
      end
   end

endmodule

// File: rtl/modiff_scheduler.sv
// Lag-sweep scheduler: issues one difference computation per lag, reports best lag and voiced flag.
// Latency: frame_valid to pitch_valid = 1 + (MAX_TAU-MIN_TAU+1)*(L+2) + 1 cycles for datapath latency L.
// Backpressure: frames arriving while not IDLE are dropped and flag sticky overrun; waits indefinitely on diff_ready.
// Build option: MODIFF_SCHED_EARLY_EXIT_EN stops the sweep at the first lag whose difference is below threshold.
module modiff_scheduler
   import modiff_pkg::*;
#(
   parameter int DIFF_WIDTH = MODIFF_DIFF_WIDTH,
   parameter int MAX_TAU    = MODIFF_MAX_TAU,
   parameter int MIN_TAU    = MODIFF_MIN_TAU,
   parameter int TAU_WIDTH  = MODIFF_TAU_WIDTH
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   output logic                  diff_start,
   output logic [TAU_WIDTH-1:0]  diff_tau,
   input  logic                  diff_ready,
   input  logic [DIFF_WIDTH-1:0] diff_value,
   input  logic [DIFF_WIDTH-1:0] threshold,
   output logic                  pitch_valid,
   output logic [TAU_WIDTH-1:0]  pitch_tau,
   output logic [DIFF_WIDTH-1:0] pitch_diff,
   output logic                  voiced,
   output logic                  busy,
   output logic                  overrun
);

   state_t                state, state_nxt;
   logic [TAU_WIDTH-1:0]  tau;
   logic [DIFF_WIDTH-1:0] thr_q;
   logic [DIFF_WIDTH-1:0] diff_q;
   logic [TAU_WIDTH-1:0]  best_tau;
   logic [DIFF_WIDTH-1:0] best_diff;
   logic                  accept;
   logic                  last_tau;
   logic                  sweep_done;

   assign accept   = (state == IDLE) && frame_valid;
   assign last_tau = (tau == TAU_WIDTH'(MAX_TAU));

`ifdef MODIFF_SCHED_EARLY_EXIT_EN
   // First dip below threshold ends the sweep; the tracker has already taken this lag since it beats every earlier one.
   assign sweep_done = last_tau || (diff_q < thr_q);
`else
   assign sweep_done = last_tau;
`endif

   assign diff_tau    = tau;
   assign frame_ready = (state == IDLE);
   assign busy        = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the single-cycle datapath start strobe.
   always_comb begin
      state_nxt  = state;
      diff_start = 1'b0;
      case (state)
         IDLE:    if (frame_valid) state_nxt = ISSUE;
         ISSUE: begin
            diff_start = 1'b1;
            state_nxt  = WAIT;
         end
         WAIT:    if (diff_ready) state_nxt = EVAL;
         EVAL:    state_nxt = sweep_done ? REPORT : ISSUE;
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Lag counter, threshold latch and captured datapath result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tau    <= TAU_WIDTH'(MIN_TAU);
         thr_q  <= '0;
         diff_q <= '0;
      end else begin
         if (accept) begin
            tau   <= TAU_WIDTH'(MIN_TAU);
            thr_q <= threshold;
         end else if ((state == EVAL) && !sweep_done) begin
            tau <= tau + TAU_WIDTH'(1);
         end
         if ((state == WAIT) && diff_ready) begin
            diff_q <= diff_value;
         end
      end
   end

   modiff_min_tracker #(
      .DIFF_WIDTH (DIFF_WIDTH),
      .TAU_WIDTH  (TAU_WIDTH),
      .MIN_TAU    (MIN_TAU)
   ) u_min_tracker (
      .clk       (clk),
      .reset     (reset),
      .clear     (accept),
      .update    (state == EVAL),
      .cand_tau  (tau),
      .cand_diff (diff_q),
      .best_tau  (best_tau),
      .best_diff (best_diff)
   );

   // Result registers: pulse pitch_valid after REPORT and hold the fields; overrun latches any dropped frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pitch_valid <= 1'b0;
         pitch_tau   <= '0;
         pitch_diff  <= '0;
         voiced      <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         pitch_valid <= (state == REPORT);
         if (state == REPORT) begin
            pitch_tau  <= best_tau;
            pitch_diff <= best_diff;
            voiced     <= (best_diff < thr_q);
         end
         if (frame_valid && (state != IDLE)) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_modiff_scheduler.sv
// Bench for modiff_scheduler: datapath model with fixed latency, scoreboard of expected frame results.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_modiff_scheduler;

   localparam int DW   = 24;
   localparam int TW   = 6;
   localparam int MAXT = 40;
   localparam int MINT = 2;
   localparam int L    = 3;

   typedef struct {
      int tau;
      int diff;
      bit voiced;
      int lat;
      int n;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          frame_valid = 1'b0;
   logic          diff_ready;
   logic [DW-1:0] diff_value;
   logic [DW-1:0] threshold = '0;
   logic          frame_ready, diff_start, pitch_valid, voiced, busy, overrun;
   logic [TW-1:0] diff_tau, pitch_tau;
   logic [DW-1:0] pitch_diff;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   mode = 0;
   int   late_req = 0;
   int   t0 = 0;
   exp_t sb[$];
   int   issued[$];
   bit   got_pv;
   int   pv_cyc, stable_err, p_tau, p_diff;
   bit   p_voiced;

   modiff_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .diff_start  (diff_start),
      .diff_tau    (diff_tau),
      .diff_ready  (diff_ready),
      .diff_value  (diff_value),
      .threshold   (threshold),
      .pitch_valid (pitch_valid),
      .pitch_tau   (pitch_tau),
      .pitch_diff  (pitch_diff),
      .voiced      (voiced),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int dp_func(input int m, input int t);
      case (m)
         0:       return ((t > 20) ? (t - 20) : (20 - t)) * 100;
         1:       return 1000;
         default: return (t < 8) ? 900 : 100;
      endcase
   endfunction

   // Reference result of one frame straight from the behavioural description.
   function automatic exp_t model(input int m, input int thr);
      exp_t e;
      int   best;
      best  = 24'hFFFFFF;
      e.tau = MINT;
      e.n   = 0;
      for (int t = MINT; t <= MAXT; t++) begin
         int d;
         d = dp_func(m, t);
         e.n++;
         if (d < best) begin
            best  = d;
            e.tau = t;
         end
`ifdef MODIFF_SCHED_EARLY_EXIT_EN
         if (d < thr) break;
`endif
      end
      e.diff   = best;
      e.voiced = (best < thr);
      e.lat    = 1 + e.n * (L + 2) + 1;
      return e;
   endfunction

   // Datapath model: diff_ready L cycles after diff_start; also emits one stray pulse on request.
   initial begin : datapath
      int cnt;
      int cur;
      int seen;
      cnt = 0; cur = 0; seen = 0;
      diff_ready = 1'b0;
      diff_value = '0;
      forever begin
         @(negedge clk);
         diff_ready = 1'b0;
         if (late_req != seen) begin
            seen       = late_req;
            diff_ready = 1'b1;
            diff_value = 24'h000011;
         end else if (diff_start) begin
            cnt = L;
            cur = int'(diff_tau);
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               diff_ready = 1'b1;
               diff_value = DW'(dp_func(mode, cur));
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk); #1;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic start_frame(input int m, input int thr);
      @(negedge clk); #1;
      mode        = m;
      threshold   = DW'(thr);
      frame_valid = 1'b1;
      t0          = cyc;
      sb.push_back(model(m, thr));
   endtask

   // Observes the DUT for up to max_cyc cycles; optionally pulses frame_valid or changes threshold at a given cycle.
   task automatic watch(input int max_cyc, input int inject_at, input int thr_at);
      bit active;
      int cur;
      active = 0; cur = 0;
      got_pv = 0; stable_err = 0; pv_cyc = 0;
      issued.delete();
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk); #1;
         frame_valid = (i == inject_at);
         if (i == thr_at) threshold = '1;
         if (diff_start) begin
            issued.push_back(int'(diff_tau));
            cur    = int'(diff_tau);
            active = 1;
         end else if (active) begin
            if (int'(diff_tau) != cur) stable_err++;
            if (diff_ready) active = 0;
         end
         if (pitch_valid) begin
            got_pv   = 1;
            pv_cyc   = cyc;
            p_tau    = int'(pitch_tau);
            p_diff   = int'(pitch_diff);
            p_voiced = voiced;
            break;
         end
      end
      frame_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk); #1;
      n_checks++; if (diff_start !== 1'b0)  begin n_fail++; $display("FAIL reset_diff_start got=%0b want=0", diff_start); end
      n_checks++; if (pitch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pitch_valid got=%0b want=0", pitch_valid); end
      n_checks++; if (voiced !== 1'b0)      begin n_fail++; $display("FAIL reset_voiced got=%0b want=0", voiced); end
      n_checks++; if (overrun !== 1'b0)     begin n_fail++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
      n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got=%0b want=0", busy); end
      n_checks++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL reset_frame_ready got=%0b want=1", frame_ready); end
      n_checks++; if (diff_tau !== TW'(MINT)) begin n_fail++; $display("FAIL reset_diff_tau got=%0d want=%0d", diff_tau, MINT); end
      n_checks++; if (pitch_tau !== '0)     begin n_fail++; $display("FAIL reset_pitch_tau got=%0d want=0", pitch_tau); end
      n_checks++; if (pitch_diff !== '0)    begin n_fail++; $display("FAIL reset_pitch_diff got=%0d want=0", pitch_diff); end
   endtask

   task automatic test_sweep();
      exp_t e;
      int   bad_seq;
      int   want_tau;
`ifdef MODIFF_SCHED_EARLY_EXIT_EN
      want_tau = 16;
`else
      want_tau = 20;
`endif
      start_frame(0, 500);
      watch(400, -1, -1);
      e = sb.pop_front();
      bad_seq = 0;
      foreach (issued[k]) if (issued[k] != MINT + k) bad_seq++;
      n_checks++; if (got_pv !== 1'b1) begin n_fail++; $display("FAIL sweep_pitch_valid got=%0b want=1", got_pv); end
      n_checks++; if (pv_cyc - t0 != e.lat) begin n_fail++; $display("FAIL sweep_latency got=%0d want=%0d", pv_cyc - t0, e.lat); end
      n_checks++; if (issued.size() != e.n) begin n_fail++; $display("FAIL sweep_issue_count got=%0d want=%0d", issued.size(), e.n); end
      n_checks++; if (bad_seq != 0) begin n_fail++; $display("FAIL sweep_tau_order got=%0d_bad want=0_bad", bad_seq); end
      n_checks++; if (stable_err != 0) begin n_fail++; $display("FAIL sweep_tau_stable got=%0d_changes want=0", stable_err); end
      n_checks++; if (p_tau != e.tau) begin n_fail++; $display("FAIL sweep_pitch_tau got=%0d want=%0d", p_tau, e.tau); end
      n_checks++; if (p_tau != want_tau) begin n_fail++; $display("FAIL sweep_pitch_tau_const got=%0d want=%0d", p_tau, want_tau); end
      n_checks++; if (p_diff != e.diff) begin n_fail++; $display("FAIL sweep_pitch_diff got=%0d want=%0d", p_diff, e.diff); end
      n_checks++; if (p_voiced !== e.voiced) begin n_fail++; $display("FAIL sweep_voiced got=%0b want=%0b", p_voiced, e.voiced); end
      @(negedge clk); #1;
      n_checks++; if (pitch_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_pulse_width got=%0b want=0", pitch_valid); end
      n_checks++; if (pitch_tau !== TW'(e.tau)) begin n_fail++; $display("FAIL sweep_tau_held got=%0d want=%0d", pitch_tau, e.tau); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL sweep_overrun got=%0b want=0", overrun); end
   endtask

   // Constant difference (tie rule), threshold raised mid-sweep, and a frame offered in the REPORT cycle.
   task automatic test_tie_report_edge();
      exp_t e;
      e = model(1, 500);
      start_frame(1, 500);
      watch(400, e.lat - 2, 20);
      e = sb.pop_front();
      n_checks++; if (got_pv !== 1'b1) begin n_fail++; $display("FAIL tie_pitch_valid got=%0b want=1", got_pv); end
      n_checks++; if (pv_cyc - t0 != e.lat) begin n_fail++; $display("FAIL tie_latency got=%0d want=%0d", pv_cyc - t0, e.lat); end
      n_checks++; if (p_tau != 2) begin n_fail++; $display("FAIL tie_pitch_tau got=%0d want=2", p_tau); end
      n_checks++; if (p_diff != 1000) begin n_fail++; $display("FAIL tie_pitch_diff got=%0d want=1000", p_diff); end
      n_checks++; if (p_voiced !== 1'b0) begin n_fail++; $display("FAIL tie_voiced got=%0b want=0", p_voiced); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL report_edge_overrun got=%0b want=1", overrun); end
      @(negedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL report_edge_dropped got_busy=%0b want=0", busy); end
      threshold = DW'(500);
   endtask

   task automatic test_reset_abort();
      bit found;
      found = 0;
      start_frame(0, 500);
      void'(sb.pop_back());
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk); #1;
         frame_valid = 1'b0;
         if (diff_start && diff_tau == TW'(10)) found = 1;
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL abort_reach_tau10 got=%0b want=1", found); end
      @(negedge clk); #1;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      late_req++;
      watch(30, -1, -1);
      n_checks++; if (got_pv !== 1'b0) begin n_fail++; $display("FAIL abort_pitch_valid got=%0b want=0", got_pv); end
      n_checks++; if (issued.size() != 0) begin n_fail++; $display("FAIL abort_diff_start got=%0d want=0", issued.size()); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%0b want=0", busy); end
      n_checks++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL abort_frame_ready got=%0b want=1", frame_ready); end
      n_checks++; if (diff_tau !== TW'(MINT)) begin n_fail++; $display("FAIL abort_diff_tau got=%0d want=%0d", diff_tau, MINT); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL abort_overrun_clear got=%0b want=0", overrun); end
   endtask

   task automatic test_overrun();
      exp_t e;
      start_frame(0, 500);
      watch(400, 50, -1);
      e = sb.pop_front();
      n_checks++; if (got_pv !== 1'b1) begin n_fail++; $display("FAIL ovr_pitch_valid got=%0b want=1", got_pv); end
      n_checks++; if (pv_cyc - t0 != e.lat) begin n_fail++; $display("FAIL ovr_latency got=%0d want=%0d", pv_cyc - t0, e.lat); end
      n_checks++; if (p_tau != e.tau) begin n_fail++; $display("FAIL ovr_pitch_tau got=%0d want=%0d", p_tau, e.tau); end
      n_checks++; if (p_diff != e.diff) begin n_fail++; $display("FAIL ovr_pitch_diff got=%0d want=%0d", p_diff, e.diff); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%0b want=1", overrun); end
      start_frame(1, 500);
      watch(400, -1, -1);
      e = sb.pop_front();
      n_checks++; if (p_tau != e.tau || p_diff != e.diff) begin n_fail++; $display("FAIL ovr_next_frame got=%0d/%0d want=%0d/%0d", p_tau, p_diff, e.tau, e.diff); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got=%0b want=1", overrun); end
   endtask

   task automatic test_early_exit();
      exp_t e;
      int   want_last, want_lat;
`ifdef MODIFF_SCHED_EARLY_EXIT_EN
      want_last = 8;
      want_lat  = 37;
`else
      want_last = 40;
      want_lat  = 197;
`endif
      start_frame(2, 500);
      watch(400, -1, -1);
      e = sb.pop_front();
      n_checks++; if (got_pv !== 1'b1) begin n_fail++; $display("FAIL dip_pitch_valid got=%0b want=1", got_pv); end
      n_checks++; if (pv_cyc - t0 != want_lat) begin n_fail++; $display("FAIL dip_latency got=%0d want=%0d", pv_cyc - t0, want_lat); end
      n_checks++; if (pv_cyc - t0 != e.lat) begin n_fail++; $display("FAIL dip_latency_model got=%0d want=%0d", pv_cyc - t0, e.lat); end
      n_checks++; if ((issued.size() > 0 ? issued[$] : -1) != want_last) begin n_fail++; $display("FAIL dip_last_issue got=%0d want=%0d", (issued.size() > 0 ? issued[$] : -1), want_last); end
      n_checks++; if (p_tau != 8) begin n_fail++; $display("FAIL dip_pitch_tau got=%0d want=8", p_tau); end
      n_checks++; if (p_diff != 100) begin n_fail++; $display("FAIL dip_pitch_diff got=%0d want=100", p_diff); end
      n_checks++; if (p_voiced !== 1'b1) begin n_fail++; $display("FAIL dip_voiced got=%0b want=1", p_voiced); end
      do_reset();
      @(negedge clk); #1;
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL final_overrun_clear got=%0b want=0", overrun); end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_tie_report_edge();
      test_reset_abort();
      test_overrun();
      test_early_exit();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/modiff_scheduler.md
Name: modiff_scheduler

Overview:
- Sequences the modiff difference datapath for one analysis frame: sweeps the lag tau from MIN_TAU to MAX_TAU and issues one difference computation per lag.
- Tracks the minimum difference across the sweep and reports the best lag plus a voiced flag to the pitch back-end.
- Sits between the sample-buffer frame trigger and the modiff datapath, one instance per datapath.

Parameters:
DIFF_WIDTH, 24, width of the difference value returned by the datapath (unsigned)
MAX_TAU, 40, last lag evaluated (40 = 20 ms at FS 2000)
MIN_TAU, 2, first lag evaluated; must satisfy 1 <= MIN_TAU <= MAX_TAU
TAU_WIDTH, 6, width of lag fields; must satisfy 2^TAU_WIDTH > MAX_TAU

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on the next clk edge)
frame_valid  in  1  one-cycle pulse: a new window is available in the buffer
frame_ready  out  1  high only in IDLE
diff_start  out  1  one-cycle pulse: datapath starts a computation for diff_tau
diff_tau  out  TAU_WIDTH  lag for the current computation; stable from diff_start until diff_ready
diff_ready  in  1  one-cycle pulse from the datapath: diff_value is valid
diff_value  in  DIFF_WIDTH  difference result for diff_tau
threshold  in  DIFF_WIDTH  voicing threshold; sampled on frame acceptance
pitch_valid  out  1  one-cycle pulse: result fields are valid
pitch_tau  out  TAU_WIDTH  best lag; held until the next pitch_valid
pitch_diff  out  DIFF_WIDTH  difference at the best lag; held
voiced  out  1  pitch_diff < latched threshold; held
busy  out  1  high in every state except IDLE
overrun  out  1  sticky; set when a frame is dropped

Behaviour:
- Reset values (reset==0):
  - state = IDLE.
  - diff_start, pitch_valid, voiced, overrun, busy = 0.
  - diff_tau = MIN_TAU.
  - pitch_tau = 0, pitch_diff = 0.
  - Best-value registers cleared.
- Reset asserted mid-sweep aborts the sweep with no pitch_valid. Any datapath diff_ready that arrives after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, EVAL, REPORT.
- IDLE: on frame_valid:
  - latch threshold; set tau = MIN_TAU; set best_diff = all-ones, best_tau = MIN_TAU.
  - go to ISSUE.
- ISSUE: diff_start = 1 for exactly one cycle, with diff_tau = tau. Next state is WAIT.
- WAIT: hold until diff_ready, then register diff_value and go to EVAL. No timeout.
- EVAL (one cycle):
  - If diff_value < best_diff (strict), update best_diff and best_tau. Ties keep the smaller lag.
  - If tau == MAX_TAU, go to REPORT; otherwise tau <= tau+1 and go to ISSUE.
- REPORT:
  - pitch_valid = 1 for one cycle.
  - pitch_tau = best_tau; pitch_diff = best_diff; voiced = (best_diff < latched threshold).
  - Next state is IDLE.
- Latency with a datapath latency of L cycles (diff_start to diff_ready):
  - per lag: L + 2 cycles;
  - full frame: frame_valid to pitch_valid = 1 + (MAX_TAU-MIN_TAU+1)*(L+2) + 1 cycles.
- frame_valid outside IDLE: the frame is dropped, overrun is set (sticky until reset), and the current sweep is unaffected.
- diff_ready outside WAIT is ignored.
- frame_valid in the same cycle that REPORT returns to IDLE counts as outside IDLE: dropped, overrun set.
- Comparisons are unsigned, full DIFF_WIDTH; no saturation needed.
- threshold changes mid-sweep have no effect.

Optional Feature:
- Macro: MODIFF_SCHED_EARLY_EXIT_EN.
- Defined:
  - In EVAL, if diff_value < latched threshold, go straight to REPORT with that lag and value (voiced = 1). This is the first-dip rule and avoids octave errors.
  - The remaining lags are not issued.
  - If no lag dips below threshold, behaviour equals the full sweep.
- Undefined: always sweep all lags and report the global minimum.

Decomposition:
- Shared package modiff_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, EVAL, REPORT);
  - default constants MODIFF_MAX_TAU=40, MODIFF_MIN_TAU=2, MODIFF_DIFF_WIDTH=24;
  - a tau_t typedef sized by TAU_WIDTH.
- One natural sub-module, modiff_min_tracker: the best-value registers plus the compare/update logic (clear, update, best_tau, best_diff).
- The FSM stays in modiff_scheduler.

Test Plan:
1. Reset low 2 cycles, then high. Expect all outputs at reset values, frame_ready = 1, busy = 0.
2. Datapath model with L=3 returning diff = |tau-20|*100, threshold = 500, frame_valid pulse.
   - Expect 39 diff_start pulses with tau 2..40, each diff_tau stable until diff_ready.
   - Expect pitch_valid exactly 1 + 39*5 + 1 = 197 cycles after frame_valid, with pitch_tau = 20, pitch_diff = 0, voiced = 1.
3. Constant diff = 1000, threshold = 500.
   - Expect pitch_tau = 2 (tie keeps the smaller lag), pitch_diff = 1000, voiced = 0.
4. Second frame_valid while busy: sweep result unchanged, overrun = 1 and held through the next frame, cleared only by reset.
5. Reset low in WAIT at tau = 10, then a late diff_ready pulse: no pitch_valid, state IDLE, diff_tau = 2, late pulse ignored.
6. With MODIFF_SCHED_EARLY_EXIT_EN, diff = 900 for tau < 8 and 100 otherwise, threshold = 500:
   - expect the last diff_start at tau = 8, then pitch_tau = 8, voiced = 1, pitch_valid 1 + 7*5 + 1 = 37 cycles after frame_valid.
